handshake_rr_arbiter: RTL and testbench
=======================================

Name: handshake_rr_arbiter

Overview:
- Shares one downstream valid/ready slave port among NUM_REQ upstream requesters, each using the same valid/ready/32-bit data handshake.
- Round-robin arbitration. One word is transferred per grant.
- The accepted word is held in an internal register and replayed to the slave until the slave accepts it.
- Sits between several handshake masters and a single handshake slave (data sink).

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 32, data width per requester and downstream.
- IDW (localparam), clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- s_valid  input  NUM_REQ  per-requester valid.
- s_data  input  NUM_REQ*DATA_W  flattened requester data; requester i at bits [i*DATA_W +: DATA_W].
- s_ready  output  NUM_REQ  per-requester ready, registered, at most one bit high.
- m_valid  output  1  downstream valid, registered.
- m_data  output  DATA_W  downstream data from the hold register.
- m_ready  input  1  downstream ready.
- grant_id  output  IDW  index of the current or last granted requester.
- busy  output  1  high whenever state != ARB.
- proto_err  output  1  one-cycle pulse when the granted requester drops valid before its handshake.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at posedge), regardless of state:
  - state=ARB, s_ready=0, m_valid=0, m_data=0, grant_id=0, rr_ptr=0, busy=0, proto_err=0.
  - Reset mid-transfer discards the held word; no handshake completes on that edge.
- FSM states ARB, ACCEPT, SEND:
  - ARB: if any s_valid bit is set, the winner is the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Register grant_id=winner, set s_ready[winner]=1, go to ACCEPT. If no s_valid bit is set, stay in ARB with all outputs idle.
  - ACCEPT, s_valid[grant_id]=1 (handshake this cycle): hold register <= s_data[grant_id], s_ready <= 0, m_valid <= 1, go to SEND.
  - ACCEPT, s_valid[grant_id]=0 (protocol violation): s_ready <= 0, proto_err pulses 1 cycle, rr_ptr is unchanged, return to ARB. No data is captured.
  - SEND: m_valid and m_data are held stable until m_ready=1. On m_valid&&m_ready: m_valid <= 0, rr_ptr <= (grant_id+1) mod NUM_REQ, go to ARB.
- Latency, with s_valid[i] rising in cycle 0 while in ARB:
  - s_ready[i]=1 in cycle 1.
  - Word captured at the end of cycle 1.
  - m_valid=1 in cycle 2.
  - If m_ready=1 in cycle 2, the FSM is back in ARB in cycle 3.
  - Peak throughput: 1 word per 3 cycles.
- Handshake rules:
  - Downstream: m_valid never depends combinationally on m_ready, and never deasserts without a handshake, except on reset.
  - Upstream: non-granted requesters see s_ready=0 and must hold valid; the arbiter never drops them.
- Fairness: a requester that stays valid is granted within NUM_REQ grants.
- grant_id keeps its last value in ARB.
- rr_ptr wraps: grant to NUM_REQ-1 gives rr_ptr=0.
- Simultaneous requests from all requesters: serviced strictly in rotating order starting at rr_ptr.
- m_ready held high continuously is allowed; no transfer is lost or duplicated.
- Words from one requester are delivered in order; interleaving across requesters follows the grant order.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random s_valid -> s_ready=0, m_valid=0, m_data=0, grant_id=0, busy=0.
- Single requester: s_valid=4'b0100 with s_data[2]=32'hDEADBEEF, m_ready=1 -> s_ready=4'b0100 one cycle later; m_valid=1 with m_data=32'hDEADBEEF two cycles after s_valid; grant_id=2; rr_ptr becomes 3.
- All four requesting continuously, data = 32'h10+i, m_ready=1 -> m_data sequence 32'h10, 11, 12, 13, 10, ... with one word every 3 cycles.
- Backpressure: m_ready=0 for 5 cycles during SEND -> m_valid and m_data stable for all 5 cycles, no s_ready asserted; on m_ready=1, exactly one transfer.
- Wrap: rr_ptr=3 with requesters 3 and 0 valid -> grant order is 3 then 0; rr_ptr ends at 1.
- Error/reset mid-op: drop s_valid[1] while in ACCEPT -> proto_err=1 for 1 cycle, no m_valid, FSM in ARB. Assert rst during SEND -> m_valid=0 next cycle and the held word is never delivered.

Source files
------------

// File: rtl/handshake_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ upstream requesters, the arbiter and one downstream sink.
// The slave modport is the arbiter's view; master is the environment driving it.
interface handshake_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        s_valid;
  logic [NUM_REQ*DATA_W-1:0] s_data;
  logic [NUM_REQ-1:0]        s_ready;
  logic                      m_valid;
  logic [DATA_W-1:0]         m_data;
  logic                      m_ready;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ valid/ready requesters into one valid/ready sink,
// one word per grant, with the accepted word held and replayed until the sink takes it.
module handshake_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 32,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  handshake_rr_arbiter_if.slave bus,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    ST_ARB,
    ST_ACCEPT,
    ST_SEND
  } state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [DATA_W-1:0]  hold_q;
  logic [NUM_REQ-1:0] s_ready_q;
  logic               m_valid_q;

  logic               any_req;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     next_ptr;
  logic [DATA_W-1:0]  req_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data[i] = bus.s_data[i*DATA_W +: DATA_W];
  end

  // Search rr_ptr, rr_ptr+1, ... (mod NUM_REQ); the first hit at the lowest offset wins.
  always_comb begin
    logic [IDW:0] sum;
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    any_req = 1'b0;
    winner  = rr_ptr;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (!any_req && bus.s_valid[sum[IDW-1:0]]) begin
        any_req = 1'b1;
        winner  = sum[IDW-1:0];
      end
    end
  end

  assign next_ptr = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + IDW'(1);

  // NOTE: all state below uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      grant_id  <= '0;
      s_ready_q <= '0;
      m_valid_q <= 1'b0;
      // NOTE: the hold register is reset too, because m_data is visible and must read
      // zero after reset; a pure data register would normally be left unreset.
      hold_q    <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      unique case (state)
        ST_ARB: begin
          if (any_req) begin
            grant_id  <= winner;
            s_ready_q <= NUM_REQ'(1) << winner;
            state     <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          s_ready_q <= '0;
          if (bus.s_valid[grant_id]) begin
            hold_q    <= req_data[grant_id];
            m_valid_q <= 1'b1;
            state     <= ST_SEND;
          end else begin
            // Granted requester withdrew: flag it and re-arbitrate from the same pointer.
            proto_err <= 1'b1;
            state     <= ST_ARB;
          end
        end
        ST_SEND: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            rr_ptr    <= next_ptr;
            state     <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = hold_q;
  assign busy        = (state != ST_ARB);

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench for handshake_rr_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level round-robin model with per-requester word queues.
module tb_handshake_rr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           proto_err;

  handshake_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  handshake_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state for the randomized run.
  logic [DW-1:0] rq [N][$];
  logic [DW-1:0] exp_q [$];
  int            model_ptr;
  int            last_grant;
  logic [N-1:0]  prev_sv, prev_sr;
  logic          prev_mv, prev_mr, prev_busy;
  logic [DW-1:0] prev_md;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    bus.s_data[i*DW +: DW] = d;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset(input int cycles);
    rst         = 1'b1;
    bus.s_valid = N'($urandom);
    bus.m_ready = 1'($urandom);
    repeat (cycles) tick();
    rst         = 1'b0;
    bus.s_valid = '0;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.m_ready = 1'($urandom);
    for (int c = 0; c < 2; c++) begin
      bus.s_valid = N'($urandom);
      bus.s_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    total_cnt++; if (bus.s_ready !== '0) $display("FAIL reset_s_ready got %b want 0000", bus.s_ready); else pass_cnt++;
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", bus.m_valid); else pass_cnt++;
    total_cnt++; if (bus.m_data !== '0) $display("FAIL reset_m_data got %h want 0", bus.m_data); else pass_cnt++;
    total_cnt++; if (grant_id !== '0) $display("FAIL reset_grant_id got %0d want 0", grant_id); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got %b want 0", proto_err); else pass_cnt++;
    rst         = 1'b0;
    bus.s_valid = '0;
    bus.m_ready = 1'b0;
    tick();
  endtask

  // rr_ptr is 0 on entry; leaves it at 3.
  task automatic test_single();
    bus.s_valid = 4'b0100;
    set_data(2, 32'hDEADBEEF);
    bus.m_ready = 1'b1;
    tick();
    total_cnt++; if (bus.s_ready !== 4'b0100) $display("FAIL single_s_ready got %b want 0100", bus.s_ready); else pass_cnt++;
    total_cnt++; if (grant_id !== 2'd2) $display("FAIL single_grant_id got %0d want 2", grant_id); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1 || bus.m_valid !== 1'b0) $display("FAIL single_c1 busy=%b m_valid=%b want 1/0", busy, bus.m_valid); else pass_cnt++;
    tick();
    bus.s_valid = '0;
    total_cnt++; if (bus.m_valid !== 1'b1) $display("FAIL single_m_valid got %b want 1", bus.m_valid); else pass_cnt++;
    total_cnt++; if (bus.m_data !== 32'hDEADBEEF) $display("FAIL single_m_data got %h want deadbeef", bus.m_data); else pass_cnt++;
    total_cnt++; if (bus.s_ready !== '0) $display("FAIL single_s_ready_c2 got %b want 0000", bus.s_ready); else pass_cnt++;
    tick();
    total_cnt++; if (bus.m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_c3 m_valid=%b busy=%b want 0/0", bus.m_valid, busy); else pass_cnt++;
  endtask

  // rr_ptr is 3 on entry: requesters 3 and 0 must be granted 3 then 0, leaving rr_ptr at 1.
  task automatic test_wrap();
    bus.s_valid = 4'b1001;
    set_data(3, 32'h33);
    set_data(0, 32'h30);
    set_data(1, 32'h31);
    set_data(2, 32'h32);
    bus.m_ready = 1'b1;
    tick();
    total_cnt++; if (bus.s_ready !== 4'b1000 || grant_id !== 2'd3) $display("FAIL wrap_first_grant got %b/%0d want 1000/3", bus.s_ready, grant_id); else pass_cnt++;
    tick();
    bus.s_valid = 4'b0001;
    total_cnt++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h33) $display("FAIL wrap_first_word got %b/%h want 1/33", bus.m_valid, bus.m_data); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.s_ready !== 4'b0001 || grant_id !== 2'd0) $display("FAIL wrap_second_grant got %b/%0d want 0001/0", bus.s_ready, grant_id); else pass_cnt++;
    tick();
    bus.s_valid = 4'b1111;
    total_cnt++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h30) $display("FAIL wrap_second_word got %b/%h want 1/30", bus.m_valid, bus.m_data); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.s_ready !== 4'b0010 || grant_id !== 2'd1) $display("FAIL wrap_ptr_after got %b/%0d want 0010/1", bus.s_ready, grant_id); else pass_cnt++;
    do_reset(1);
  endtask

  task automatic test_round_robin();
    int n    = 0;
    int last = -1;
    do_reset(1);
    for (int i = 0; i < N; i++) set_data(i, 32'h10 + i);
    bus.s_valid = 4'b1111;
    bus.m_ready = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (bus.m_valid) begin
        total_cnt++;
        if (bus.m_data !== 32'h10 + (n % N)) $display("FAIL rr_word%0d got %h want %h", n, bus.m_data, 32'h10 + (n % N));
        else pass_cnt++;
        if (last >= 0) begin
          total_cnt++;
          if (c - last !== 3) $display("FAIL rr_spacing%0d got %0d cycles want 3", n, c - last);
          else pass_cnt++;
        end
        last = c;
        n++;
      end
    end
    total_cnt++; if (n !== 9) $display("FAIL rr_word_count got %0d want 9", n); else pass_cnt++;
    do_reset(1);
  endtask

  task automatic test_backpressure();
    int early = 0;
    set_data(1, 32'hCAFE0001);
    set_data(0, 32'hCAFE0000);
    bus.s_valid = 4'b0010;
    bus.m_ready = 1'b0;
    tick();
    tick();
    bus.s_valid = 4'b0001;
    total_cnt++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hCAFE0001) $display("FAIL bp_start got %b/%h want 1/cafe0001", bus.m_valid, bus.m_data); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      tick();
      total_cnt++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hCAFE0001 || bus.s_ready !== '0)
        $display("FAIL bp_hold%0d got m_valid=%b m_data=%h s_ready=%b want 1/cafe0001/0000", c, bus.m_valid, bus.m_data, bus.s_ready);
      else pass_cnt++;
    end
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    total_cnt++; if (bus.m_valid !== 1'b0) $display("FAIL bp_release got m_valid=%b want 0", bus.m_valid); else pass_cnt++;
    tick();
    early = bus.m_valid;
    total_cnt++; if (early !== 0 || bus.s_ready !== 4'b0001) $display("FAIL bp_next got m_valid=%0d s_ready=%b want 0/0001", early, bus.s_ready); else pass_cnt++;
    do_reset(1);
  endtask

  task automatic test_proto_err();
    bus.s_valid = 4'b0010;
    set_data(1, 32'h1111_1111);
    bus.m_ready = 1'b1;
    tick();
    total_cnt++; if (bus.s_ready !== 4'b0010) $display("FAIL perr_grant got %b want 0010", bus.s_ready); else pass_cnt++;
    bus.s_valid = '0;
    tick();
    total_cnt++; if (proto_err !== 1'b1) $display("FAIL perr_pulse got %b want 1", proto_err); else pass_cnt++;
    total_cnt++; if (bus.m_valid !== 1'b0 || busy !== 1'b0 || bus.s_ready !== '0) $display("FAIL perr_idle got m_valid=%b busy=%b s_ready=%b want 0/0/0000", bus.m_valid, busy, bus.s_ready); else pass_cnt++;
    tick();
    bus.s_valid = 4'b0110;
    total_cnt++; if (proto_err !== 1'b0 || bus.m_valid !== 1'b0) $display("FAIL perr_one_cycle got proto_err=%b m_valid=%b want 0/0", proto_err, bus.m_valid); else pass_cnt++;
    tick();
    total_cnt++; if (bus.s_ready !== 4'b0010 || grant_id !== 2'd1) $display("FAIL perr_ptr_kept got %b/%0d want 0010/1", bus.s_ready, grant_id); else pass_cnt++;
    do_reset(1);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bus.s_valid = 4'b0001;
    set_data(0, 32'h0BADF00D);
    bus.m_ready = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h0BADF00D) $display("FAIL rmid_send got %b/%h want 1/0badf00d", bus.m_valid, bus.m_data); else pass_cnt++;
    bus.s_valid = '0;
    rst         = 1'b1;
    tick();
    total_cnt++; if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || busy !== 1'b0) $display("FAIL rmid_cleared got m_valid=%b m_data=%h busy=%b want 0/0/0", bus.m_valid, bus.m_data, busy); else pass_cnt++;
    rst         = 1'b0;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.m_valid) seen++;
    end
    total_cnt++; if (seen !== 0) $display("FAIL rmid_no_replay got %0d valid cycles want 0", seen); else pass_cnt++;
    bus.m_ready = 1'b0;
  endtask

  // One cycle of the randomized run: score what happened at the edge, then drive new inputs.
  task automatic rand_step(input bit allow_new);
    int            w;
    logic [N-1:0]  exp_sr;
    logic [DW-1:0] exp_word;
    tick();
    if (prev_mv && prev_mr) begin
      total_cnt++;
      if (exp_q.size() == 0) $display("FAIL rand_unexpected_word got %h want none", prev_md);
      else begin
        exp_word = exp_q.pop_front();
        if (prev_md !== exp_word) $display("FAIL rand_word got %h want %h", prev_md, exp_word);
        else pass_cnt++;
      end
      model_ptr = (last_grant + 1) % N;
    end else if (prev_mv) begin
      total_cnt++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== prev_md)
        $display("FAIL rand_hold got %b/%h want 1/%h", bus.m_valid, bus.m_data, prev_md);
      else pass_cnt++;
    end
    for (int i = 0; i < N; i++)
      if (prev_sv[i] && prev_sr[i]) exp_q.push_back(rq[i].pop_front());
    if (!prev_busy) begin
      w      = rr_pick(prev_sv, model_ptr);
      exp_sr = (w >= 0) ? (N'(1) << w) : '0;
      total_cnt++;
      if (bus.s_ready !== exp_sr || (w >= 0 && grant_id !== IDW'(w)))
        $display("FAIL rand_grant got %b/%0d want %b/%0d", bus.s_ready, grant_id, exp_sr, w);
      else pass_cnt++;
      if (w >= 0) last_grant = w;
    end
    total_cnt++;
    if (proto_err !== 1'b0) $display("FAIL rand_proto_err got %b want 0", proto_err); else pass_cnt++;

    if (allow_new && $urandom_range(0, 2) == 0) begin
      w = $urandom_range(0, N-1);
      if (rq[w].size() < 4) rq[w].push_back($urandom);
    end
    bus.m_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.s_valid[i] = (rq[i].size() != 0);
      set_data(i, (rq[i].size() != 0) ? rq[i][0] : '0);
    end
    prev_sv   = bus.s_valid;
    prev_sr   = bus.s_ready;
    prev_mv   = bus.m_valid;
    prev_mr   = bus.m_ready;
    prev_md   = bus.m_data;
    prev_busy = busy;
  endtask

  task automatic test_random();
    int  c       = 0;
    bit  drained = 0;
    do_reset(1);
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    model_ptr  = 0;
    last_grant = 0;
    prev_sv    = bus.s_valid;
    prev_sr    = bus.s_ready;
    prev_mv    = bus.m_valid;
    prev_mr    = bus.m_ready;
    prev_md    = bus.m_data;
    prev_busy  = busy;
    repeat (3000) rand_step(1'b1);
    while (!drained && c < 300) begin
      rand_step(1'b0);
      c++;
      drained = (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() == 0) &&
                exp_q.size() == 0 && !bus.m_valid && !busy;
    end
    total_cnt++;
    if (!drained) $display("FAIL rand_drain got pending words after %0d cycles want none", c);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_proto_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
